simon_round_controller: RTL and testbench



---
 rtl/simon_round_controller.sv | 141 ++++++++++++++
 tb/tb_simon_round_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_controller.sv
// Simon game sequencer: replays the colour sequence, checks presses, decides advance/win/lose.
// All state changes on the falling edge of clk, the same edge the external counters use.
module simon_round_controller #(
  parameter int MAX_ROUNDS    = 16,
  parameter int ON_TICKS      = 250,
  parameter int OFF_TICKS     = 100,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  input  logic [1:0] seq_color,
  input  logic [4:0] round_count,
  input  logic [4:0] pos_count,
  output logic       round_inc,
  output logic       round_rst,
  output logic       pos_inc,
  output logic       pos_rst,
  output logic       led_on,
  output logic [1:0] led_color,
  output logic       input_phase,
  output logic       win,
  output logic       lose
);

  localparam int MAX_AB    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS = (MAX_AB > TIMEOUT_TICKS) ? MAX_AB : TIMEOUT_TICKS;
  localparam int TW        = $clog2(MAX_TICKS) + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GAP      = 3'd1;
  localparam logic [2:0] SHOW_ON  = 3'd2;
  localparam logic [2:0] SHOW_OFF = 3'd3;
  localparam logic [2:0] WAIT_IN  = 3'd4;
  localparam logic [2:0] WIN      = 3'd5;
  localparam logic [2:0] LOSE     = 3'd6;

  logic [2:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic          timer_clr;
  logic          led_on_reg, input_phase_reg, win_reg, lose_reg;
  logic          round_inc_c, round_rst_c, pos_inc_c, pos_rst_c;

  logic on_exp, off_exp, to_exp, last_pos, match, final_round;

  assign on_exp      = (timer_reg == TW'(ON_TICKS - 1));
  assign off_exp     = (timer_reg == TW'(OFF_TICKS - 1));
  assign to_exp      = (timer_reg == TW'(TIMEOUT_TICKS - 1));
  assign last_pos    = (pos_count >= round_count);
  assign match       = (btn_code == seq_color);
  assign final_round = (round_count == 5'(MAX_ROUNDS));

  always_comb begin
    state_next  = state_reg;
    timer_clr   = 1'b0;
    round_inc_c = 1'b0;
    round_rst_c = 1'b0;
    pos_inc_c   = 1'b0;
    pos_rst_c   = 1'b0;
    case (state_reg)
      IDLE, WIN, LOSE: begin
        if (start) begin
          round_rst_c = 1'b1;
          pos_rst_c   = 1'b1;
          state_next  = GAP;
        end
      end
      GAP: begin
        if (off_exp) state_next = SHOW_ON;
      end
      SHOW_ON: begin
        if (on_exp) state_next = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (off_exp) begin
          if (last_pos) begin
            pos_rst_c  = 1'b1;
            state_next = WAIT_IN;
          end else begin
            pos_inc_c  = 1'b1;
            state_next = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        // A press in the expiry cycle wins over the timeout.
        if (btn_valid) begin
          if (!match) begin
            state_next = LOSE;
          end else if (!last_pos) begin
            pos_inc_c = 1'b1;
            timer_clr = 1'b1;
          end else if (final_round) begin
            state_next = WIN;
          end else begin
            round_inc_c = 1'b1;
            pos_rst_c   = 1'b1;
            state_next  = GAP;
          end
        end else if (to_exp) begin
          state_next = LOSE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are suppressed while reset is held so the counters keep their value.
  assign round_inc = round_inc_c & reset;
  assign round_rst = round_rst_c & reset;
  assign pos_inc   = pos_inc_c & reset;
  assign pos_rst   = pos_rst_c & reset;

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      led_on_reg      <= 1'b0;
      input_phase_reg <= 1'b0;
      win_reg         <= 1'b0;
      lose_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= ((state_next != state_reg) || timer_clr) ? '0 : timer_reg + 1'b1;
      led_on_reg      <= (state_next == SHOW_ON);
      input_phase_reg <= (state_next == WAIT_IN);
      win_reg         <= (state_next == WIN);
      lose_reg        <= (state_next == LOSE);
    end
  end

  // Colour follows the sequence ROM live so a freshly incremented position shows at once.
  assign led_on      = led_on_reg;
  assign led_color   = led_on_reg ? seq_color : 2'b00;
  assign input_phase = input_phase_reg;
  assign win         = win_reg;
  assign lose        = lose_reg;

endmodule

// File: tb/tb_simon_round_controller.sv
// Directed bench for simon_round_controller with behavioural counters and a 2,0,3 sequence ROM.
// Inputs change just after the falling edge; outputs are sampled on the rising edge.
module tb_simon_round_controller;

  localparam int MAXR = 3;
  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int TO   = 20;

  logic       clk = 1'b1;
  logic       reset, start, btn_valid;
  logic [1:0] btn_code, seq_color;
  logic [4:0] round_count = 5'd0;
  logic [4:0] pos_count = 5'd0;
  logic       round_inc, round_rst, pos_inc, pos_rst;
  logic       led_on, input_phase, win, lose;
  logic [1:0] led_color;
  logic [1:0] rom [0:3];

  int n_cmp = 0;
  int n_bad = 0;

  simon_round_controller #(
    .MAX_ROUNDS(MAXR), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid), .btn_code(btn_code),
    .seq_color(seq_color), .round_count(round_count), .pos_count(pos_count),
    .round_inc(round_inc), .round_rst(round_rst), .pos_inc(pos_inc), .pos_rst(pos_rst),
    .led_on(led_on), .led_color(led_color), .input_phase(input_phase), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  initial begin
    rom[0] = 2'd0; rom[1] = 2'd2; rom[2] = 2'd0; rom[3] = 2'd3;
  end

  always_comb begin
    seq_color = 2'd0;
    if (pos_count >= 5'd1 && pos_count <= 5'd3) seq_color = rom[pos_count[1:0]];
  end

  always @(negedge clk) begin
    if (round_rst) round_count <= 5'd1;
    else if (round_inc) round_count <= round_count + 5'd1;
    if (pos_rst) pos_count <= 5'd1;
    else if (pos_inc) pos_count <= pos_count + 5'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic after_fall();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    chk("start_round_rst", 32'(round_rst), 1);
    chk("start_pos_rst", 32'(pos_rst), 1);
    chk("start_round_inc", 32'(round_inc), 0);
    after_fall();
    start = 1'b0;
    chk("start_round_count", 32'(round_count), 1);
  endtask

  // Checks the full playback of round r, leaving the bench at the start of the input phase.
  task automatic expect_show(input int r);
    for (int k = 0; k < OFF; k++) begin
      @(posedge clk);
      chk("gap_led", 32'(led_on), 0);
      chk("gap_ip", 32'(input_phase), 0);
      chk("gap_winlose", 32'({win, lose}), 0);
      after_fall();
    end
    for (int i = 1; i <= r; i++) begin
      for (int k = 0; k < ON; k++) begin
        @(posedge clk);
        chk("on_led", 32'(led_on), 1);
        chk("on_color", 32'(led_color), 32'(rom[i]));
        chk("on_pos_inc", 32'(pos_inc), 0);
        after_fall();
      end
      for (int k = 0; k < OFF; k++) begin
        @(posedge clk);
        chk("off_led", 32'(led_on), 0);
        if (k == OFF - 1) begin
          chk("off_pos_inc", 32'(pos_inc), 32'(i < r));
          chk("off_pos_rst", 32'(pos_rst), 32'(i == r));
        end
        after_fall();
      end
    end
    chk("show_end_pos", 32'(pos_count), 1);
  endtask

  task automatic press(input logic [1:0] code, input logic ip, input logic pi,
                       input logic ri, input logic pr);
    btn_valid = 1'b1;
    btn_code  = code;
    @(posedge clk);
    chk("press_ip", 32'(input_phase), 32'(ip));
    chk("press_pos_inc", 32'(pos_inc), 32'(pi));
    chk("press_round_inc", 32'(round_inc), 32'(ri));
    chk("press_pos_rst", 32'(pos_rst), 32'(pr));
    chk("press_round_rst", 32'(round_rst), 0);
    after_fall();
    btn_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic ip, input logic ls);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      chk("idle_ip", 32'(input_phase), 32'(ip));
      chk("idle_lose", 32'(lose), 32'(ls));
      after_fall();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; btn_valid = 1'b0; btn_code = 2'd0;
    // Reset held with start asserted: outputs and strobes must stay low.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      chk("rst_outs", 32'({led_on, led_color, input_phase, win, lose}), 0);
      chk("rst_strobes", 32'({round_inc, round_rst, pos_inc, pos_rst}), 0);
      after_fall();
    end
    reset = 1'b1; start = 1'b0;
    idle_cycles(2, 1'b0, 1'b0);

    // Full game to a win.
    do_start();
    expect_show(1);
    press(2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("r1_round_count", 32'(round_count), 2);
    expect_show(2);
    press(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    press(2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("r2_round_count", 32'(round_count), 3);
    expect_show(3);
    press(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    press(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    press(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    chk("win_flag", 32'(win), 1);
    chk("win_ip", 32'(input_phase), 0);
    chk("win_round_count", 32'(round_count), 3);
    after_fall();

    // Restart from WIN, then a wrong press in round 2.
    do_start();
    expect_show(1);
    press(2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_show(2);
    press(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    chk("wrong_lose", 32'(lose), 1);
    after_fall();
    press(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    chk("lose_held", 32'(lose), 1);
    chk("lose_pos_count", 32'(pos_count), 1);
    after_fall();

    // Timeout with no press.
    do_start();
    expect_show(1);
    idle_cycles(TO, 1'b1, 1'b0);
    @(posedge clk);
    chk("timeout_lose", 32'(lose), 1);
    chk("timeout_ip", 32'(input_phase), 0);
    after_fall();

    // Presses landing exactly in the expiry cycle are accepted and restart the timer.
    do_start();
    expect_show(1);
    idle_cycles(TO - 1, 1'b1, 1'b0);
    press(2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_show(2);
    idle_cycles(TO - 1, 1'b1, 1'b0);
    press(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(TO - 1, 1'b1, 1'b0);
    press(2'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset in the GAP of round 3, then a reset mid-playback of round 2.
    reset = 1'b0;
    @(posedge clk);
    chk("rst_gap_strobes", 32'({round_inc, round_rst, pos_inc, pos_rst}), 0);
    after_fall();
    reset = 1'b1;
    do_start();
    expect_show(1);
    press(2'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_cycles(OFF + 1, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    chk("midplay_start_rst", 32'({round_rst, pos_rst}), 0);
    chk("midplay_led", 32'(led_on), 1);
    after_fall();
    start = 1'b0;
    @(posedge clk);
    chk("midplay_led_kept", 32'(led_on), 1);
    chk("midplay_color", 32'(led_color), 2);
    after_fall();
    reset = 1'b0;
    @(posedge clk);
    chk("midrst_strobes", 32'({round_inc, round_rst, pos_inc, pos_rst}), 0);
    after_fall();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      chk("midrst_idle_outs", 32'({led_on, led_color, input_phase, win, lose}), 0);
      after_fall();
    end
    chk("midrst_round_kept", 32'(round_count), 2);
    do_start();
    expect_show(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
